// File: rtl/instr_fetch_unit_pkg.sv
// Shared encodings for the fetch stage: next-PC selects,
// fetch FSM states and the canonical NOP word.
package instr_fetch_unit_pkg;

  localparam logic [1:0] PC_SEL_PLUS4 = 2'b00;
  localparam logic [1:0] PC_SEL_BR    = 2'b01;
  localparam logic [1:0] PC_SEL_JAL   = 2'b10;
  localparam logic [1:0] PC_SEL_JALR  = 2'b11;

  localparam logic [1:0] IF_IDLE  = 2'd0;
  localparam logic [1:0] IF_REQ   = 2'd1;
  localparam logic [1:0] IF_HOLD  = 2'd2;
  localparam logic [1:0] IF_FAULT = 2'd3;

  localparam logic [31:0] NOP_ENC = 32'h0000_0013;

endpackage

// File: rtl/instr_fetch_unit_pc_next_gen.sv
// Next-PC generator: pc, pc_sel, br_taken, immediates, rs1 in;
// next_pc and misalign (next_pc[1:0] != 0) out. Purely combinational.
module pc_next_gen
  import instr_fetch_unit_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [1:0]  pc_sel_i,
  input  logic        br_taken_i,
  input  logic [12:0] pc_imm_add_i,
  input  logic [20:0] j_imm_i,
  input  logic [11:0] a_imm_i,
  input  logic [31:0] rs1_data_i,
  output logic [31:0] next_pc_o,
  output logic        misalign_o
);

  logic [31:0] seq_pc;
  logic [31:0] br_off;
  logic [31:0] j_off;
  logic [31:0] a_off;
  logic [31:0] jalr_sum;

  assign seq_pc   = pc_i + 32'd4;
  assign br_off   = {{19{pc_imm_add_i[12]}}, pc_imm_add_i};
  assign j_off    = {{11{j_imm_i[20]}}, j_imm_i};
  assign a_off    = {{20{a_imm_i[11]}}, a_imm_i};
  assign jalr_sum = rs1_data_i + a_off;

  always_comb begin
    next_pc_o = seq_pc;
    unique case (pc_sel_i)
      PC_SEL_PLUS4: next_pc_o = seq_pc;
      PC_SEL_BR:
        next_pc_o = br_taken_i ? (pc_i + br_off) : seq_pc;
      PC_SEL_JAL:   next_pc_o = pc_i + j_off;
      PC_SEL_JALR:  next_pc_o = jalr_sum & ~32'h1;
      default:      next_pc_o = seq_pc;
    endcase
  end

  // JALR bit0 is already cleared, so only bit1 can fault there
  assign misalign_o = |next_pc_o[1:0];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, IMEM request FSM, INSTR hold register,
// retired-instruction counter and sticky misaligned-target flag.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_ENC
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [1:0]  PC_SEL,
  input  logic        BR_TAKEN,
  input  logic [12:0] PC_IMM_ADD,
  input  logic [20:0] J_IMM,
  input  logic [11:0] A_IMM,
  input  logic [31:0] RS1_DATA,
  input  logic        INSTR_ACK,
  input  logic        STALL,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic [31:0] IMEM_RDATA,
  input  logic        IMEM_RVALID,
  output logic [31:0] INSTR,
  output logic        INSTR_VALID,
  output logic [31:0] PC,
  output logic [31:0] PC_PLUS4,
  output logic        FETCH_FAULT,
  output logic [31:0] INSTRET
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic [31:0] instret_q, instret_d;

  logic [31:0] next_pc;
  logic        misalign;
  logic        accept;

  pc_next_gen u_next (
    .pc_i         (pc_q),
    .pc_sel_i     (PC_SEL),
    .br_taken_i   (BR_TAKEN),
    .pc_imm_add_i (PC_IMM_ADD),
    .j_imm_i      (J_IMM),
    .a_imm_i      (A_IMM),
    .rs1_data_i   (RS1_DATA),
    .next_pc_o    (next_pc),
    .misalign_o   (misalign)
  );

  assign accept = (state_q == IF_HOLD) && INSTR_ACK && !STALL;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    fault_d   = fault_q;
    instret_d = instret_q;
    unique case (state_q)
      IF_IDLE: state_d = IF_REQ;
      IF_REQ: begin
        if (IMEM_RVALID) begin
          instr_d = IMEM_RDATA;
          valid_d = 1'b1;
          state_d = IF_HOLD;
        end
      end
      IF_HOLD: begin
        if (accept) begin
          pc_d      = next_pc;
          instret_d = instret_q + 32'd1;
          instr_d   = NOP_INSTR;
          valid_d   = 1'b0;
          fault_d   = misalign;
          state_d   = misalign ? IF_FAULT : IF_REQ;
        end
      end
      IF_FAULT: fault_d = 1'b1;
      default:  state_d = IF_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IF_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
      instret_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      fault_q   <= fault_d;
      instret_q <= instret_d;
    end
  end

  assign IMEM_REQ    = (state_q == IF_REQ);
  assign IMEM_ADDR   = pc_q;
  assign INSTR       = instr_q;
  assign INSTR_VALID = valid_q;
  assign PC          = pc_q;
  assign PC_PLUS4    = pc_q + 32'd4;
  assign FETCH_FAULT = fault_q;
  assign INSTRET     = instret_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a latency-programmable
// instruction memory model and immediate-assertion checks.
module tb_instr_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [1:0]  PC_SEL = 2'b00;
  logic        BR_TAKEN = 1'b0;
  logic [12:0] PC_IMM_ADD = '0;
  logic [20:0] J_IMM = '0;
  logic [11:0] A_IMM = '0;
  logic [31:0] RS1_DATA = '0;
  logic        INSTR_ACK = 1'b0;
  logic        STALL = 1'b0;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IMEM_RDATA;
  logic        IMEM_RVALID;
  logic [31:0] INSTR;
  logic        INSTR_VALID;
  logic [31:0] PC;
  logic [31:0] PC_PLUS4;
  logic        FETCH_FAULT;
  logic [31:0] INSTRET;

  int checks = 0;
  int failures = 0;

  int   mem_wait = 0;
  int   wait_cnt = 0;
  logic stray_rvalid = 1'b0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 CLK = ~CLK;

  instr_fetch_unit dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .PC_SEL      (PC_SEL),
    .BR_TAKEN    (BR_TAKEN),
    .PC_IMM_ADD  (PC_IMM_ADD),
    .J_IMM       (J_IMM),
    .A_IMM       (A_IMM),
    .RS1_DATA    (RS1_DATA),
    .INSTR_ACK   (INSTR_ACK),
    .STALL       (STALL),
    .IMEM_REQ    (IMEM_REQ),
    .IMEM_ADDR   (IMEM_ADDR),
    .IMEM_RDATA  (IMEM_RDATA),
    .IMEM_RVALID (IMEM_RVALID),
    .INSTR       (INSTR),
    .INSTR_VALID (INSTR_VALID),
    .PC          (PC),
    .PC_PLUS4    (PC_PLUS4),
    .FETCH_FAULT (FETCH_FAULT),
    .INSTRET     (INSTRET)
  );

  // Memory: word at 0 is 00500093, else {addr[19:0],12'h013}
  // rvalid after mem_wait extra cycles of a held request
  assign IMEM_RVALID = stray_rvalid |
                       (IMEM_REQ && (wait_cnt >= mem_wait));
  assign IMEM_RDATA  = stray_rvalid ? 32'hDEAD_BEEF :
                       (IMEM_ADDR == 32'd0) ? 32'h0050_0093 :
                       {IMEM_ADDR[19:0], 12'h013};

  always @(posedge CLK) begin
    if (IMEM_REQ && !IMEM_RVALID) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (INSTR_VALID !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check(tag, 32'(INSTR_VALID), 32'd1);
  endtask

  task automatic accept();
    INSTR_ACK = 1'b1;
    @(posedge CLK);
    #1 INSTR_ACK = 1'b0;
    @(negedge CLK);
  endtask

  task automatic req_run(output int n, output logic [31:0] a);
    n = 0;
    a = IMEM_ADDR;
    while (IMEM_REQ === 1'b1 && n < 20) begin
      n++;
      @(negedge CLK);
    end
  endtask

  int          nreq;
  logic [31:0] addr;

  initial begin
    // reset state
    repeat (2) @(negedge CLK);
    check("rst_req", 32'(IMEM_REQ), 32'd0);
    check("rst_instr", INSTR, NOP);
    check("rst_valid", 32'(INSTR_VALID), 32'd0);
    check("rst_pc", PC, 32'd0);
    check("rst_pc4", PC_PLUS4, 32'd4);
    check("rst_fault", 32'(FETCH_FAULT), 32'd0);
    check("rst_instret", INSTRET, 32'd0);

    // release, zero-wait memory
    @(posedge CLK);
    #1 RST_N = 1'b1;
    @(negedge CLK);
    check("idle_req", 32'(IMEM_REQ), 32'd0);
    @(negedge CLK);
    check("first_req", 32'(IMEM_REQ), 32'd1);
    check("first_addr", IMEM_ADDR, 32'd0);
    check("first_nvalid", 32'(INSTR_VALID), 32'd0);
    @(negedge CLK);
    check("first_valid", 32'(INSTR_VALID), 32'd1);
    check("first_instr", INSTR, 32'h0050_0093);
    check("first_pc", PC, 32'd0);
    check("hold_req", 32'(IMEM_REQ), 32'd0);

    // sequential fetch, 3-cycle memory
    mem_wait = 2;
    PC_SEL = 2'b00;
    accept();
    check("acc1_nvalid", 32'(INSTR_VALID), 32'd0);
    check("acc1_instr", INSTR, NOP);
    req_run(nreq, addr);
    check("seq1_addr", addr, 32'd4);
    check("seq1_nreq", 32'(nreq), 32'd3);
    check("seq1_instr", INSTR, 32'h0000_4013);
    accept();
    req_run(nreq, addr);
    check("seq2_addr", addr, 32'd8);
    check("seq2_nreq", 32'(nreq), 32'd3);
    check("seq2_instr", INSTR, 32'h0000_8013);

    // JAL 8 -> 0x100
    PC_SEL = 2'b10;
    J_IMM = 21'h0000F8;
    accept();
    check("jal_pc", PC, 32'h100);
    check("instret3", INSTRET, 32'd3);
    mem_wait = 0;

    // branch taken -8, taken +8, then not taken
    wait_valid("wv_br1");
    check("br_instr0", INSTR, 32'h0010_0013);
    PC_SEL = 2'b01;
    BR_TAKEN = 1'b1;
    PC_IMM_ADD = 13'h1FF8;
    accept();
    check("br_taken", PC, 32'hF8);
    wait_valid("wv_br2");
    check("br_instr1", INSTR, 32'h000F_8013);
    PC_IMM_ADD = 13'h0008;
    accept();
    check("br_fwd", PC, 32'h100);
    wait_valid("wv_br3");
    BR_TAKEN = 1'b0;
    PC_IMM_ADD = 13'h1FF8;
    accept();
    check("br_ntaken", PC, 32'h104);
    check("br_pc4", PC_PLUS4, 32'h108);
    check("instret6", INSTRET, 32'd6);

    // stall overrides ack
    wait_valid("wv_stall");
    PC_SEL = 2'b00;
    STALL = 1'b1;
    INSTR_ACK = 1'b1;
    repeat (4) @(negedge CLK);
    check("stall_pc", PC, 32'h104);
    check("stall_instr", INSTR, 32'h0010_4013);
    check("stall_instret", INSTRET, 32'd6);
    check("stall_valid", 32'(INSTR_VALID), 32'd1);
    check("stall_req", 32'(IMEM_REQ), 32'd0);
    STALL = 1'b0;
    @(posedge CLK);
    #1 INSTR_ACK = 1'b0;
    @(negedge CLK);
    check("unstall_pc", PC, 32'h108);
    check("unstall_instret", INSTRET, 32'd7);
    @(negedge CLK);
    check("single_acc", INSTRET, 32'd7);

    // JALR aligned, then misaligned
    wait_valid("wv_jalr");
    PC_SEL = 2'b11;
    RS1_DATA = 32'h203;
    A_IMM = 12'h001;
    accept();
    check("jalr_pc", PC, 32'h204);
    check("jalr_nfault", 32'(FETCH_FAULT), 32'd0);
    wait_valid("wv_jalr2");
    check("jalr_instr", INSTR, 32'h0020_4013);
    RS1_DATA = 32'h202;
    A_IMM = 12'h000;
    accept();
    check("flt_pc", PC, 32'h202);
    check("flt_flag", 32'(FETCH_FAULT), 32'd1);
    check("flt_req", 32'(IMEM_REQ), 32'd0);
    check("flt_valid", 32'(INSTR_VALID), 32'd0);
    INSTR_ACK = 1'b1;
    repeat (3) @(negedge CLK);
    INSTR_ACK = 1'b0;
    check("flt_req2", 32'(IMEM_REQ), 32'd0);
    check("flt_pc2", PC, 32'h202);
    check("flt_instret", INSTRET, 32'd9);
    check("flt_sticky", 32'(FETCH_FAULT), 32'd1);

    // reset mid-request at 0x40, stray rvalid in IDLE
    RST_N = 1'b0;
    @(negedge CLK);
    @(posedge CLK);
    #1 RST_N = 1'b1;
    wait_valid("wv_rst2");
    mem_wait = 3;
    PC_SEL = 2'b10;
    J_IMM = 21'h000040;
    accept();
    check("mid_req", 32'(IMEM_REQ), 32'd1);
    check("mid_addr", IMEM_ADDR, 32'h40);
    RST_N = 1'b0;
    #1;
    check("ar_req", 32'(IMEM_REQ), 32'd0);
    check("ar_pc", PC, 32'd0);
    check("ar_instr", INSTR, NOP);
    check("ar_instret", INSTRET, 32'd0);
    check("ar_fault", 32'(FETCH_FAULT), 32'd0);
    mem_wait = 0;
    @(posedge CLK);
    #1 RST_N = 1'b1;
    stray_rvalid = 1'b1;
    @(posedge CLK);
    #1 stray_rvalid = 1'b0;
    @(negedge CLK);
    check("stray_instr", INSTR, NOP);
    check("stray_valid", 32'(INSTR_VALID), 32'd0);
    check("re_req", 32'(IMEM_REQ), 32'd1);
    check("re_addr", IMEM_ADDR, 32'd0);
    @(negedge CLK);
    check("re_instr", INSTR, 32'h0050_0093);
    check("re_valid", 32'(INSTR_VALID), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
